// File: rtl/reg_scoreboard.sv
// ============================================================================
// Module   : reg_scoreboard
// Brief    : Register-hazard scoreboard with per-register latency counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_scoreboard #(
  parameter int REG_NUM        = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int READ_PORTS     = 2,
  parameter int LAT_WIDTH      = 3
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               issue_valid,
  input  logic                               issue_write_en,
  input  logic [REG_ADDR_WIDTH-1:0]          issue_write_addr,
  input  logic [LAT_WIDTH-1:0]               issue_latency,
  input  logic [READ_PORTS-1:0]              read_en,
  input  logic [READ_PORTS*REG_ADDR_WIDTH-1:0] read_addr,
  input  logic                               flush,
  output logic [READ_PORTS-1:0]              hazard_mask,
  output logic                               stall_request,
  output logic                               any_pending
);

  localparam logic [REG_ADDR_WIDTH:0] c_REG_NUM_EXT = REG_NUM[REG_ADDR_WIDTH:0];
  localparam logic [LAT_WIDTH-1:0]    c_LAT_ONE     = LAT_WIDTH'(1);

  // Register 0 is hardwired zero, so it has no counter at all.
  logic [LAT_WIDTH-1:0] cnt_q [1:REG_NUM-1];
  logic [LAT_WIDTH-1:0] cnt_d [1:REG_NUM-1];

  logic [READ_PORTS-1:0] w_hazard;
  logic                  w_any;
  logic                  w_wa_ok;
  logic                  w_accept;

  generate
    for (genvar p = 0; p < READ_PORTS; p++) begin : g_port
      logic [REG_ADDR_WIDTH-1:0] w_addr;
      assign w_addr = read_addr[p*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];

      // Decoder-style lookup: addresses 0 and >= REG_NUM never match a counter.
      always_comb begin
        w_hazard[p] = 1'b0;
        for (int r = 1; r < REG_NUM; r++) begin
          if (read_en[p] && (w_addr == REG_ADDR_WIDTH'(r)) && (cnt_q[r] != '0)) begin
            w_hazard[p] = 1'b1;
          end
        end
      end
    end
  endgenerate

  always_comb begin
    w_any = 1'b0;
    for (int r = 1; r < REG_NUM; r++) begin
      w_any = w_any | (cnt_q[r] != '0);
    end
  end

  assign hazard_mask   = w_hazard;
  assign stall_request = |w_hazard;
  assign any_pending   = w_any;

  assign w_wa_ok  = (issue_write_addr != '0) && ({1'b0, issue_write_addr} < c_REG_NUM_EXT);
  assign w_accept = issue_valid && issue_write_en && w_wa_ok && !stall_request && !flush;

  always_comb begin
    for (int r = 1; r < REG_NUM; r++) begin
      cnt_d[r] = (cnt_q[r] == '0) ? '0 : (cnt_q[r] - c_LAT_ONE);
      if (flush) begin
        cnt_d[r] = '0;
      end else if (w_accept && (issue_write_addr == REG_ADDR_WIDTH'(r))
                   && (issue_latency > cnt_d[r])) begin
        // A younger, shorter write never shortens an older pending one.
        cnt_d[r] = issue_latency;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 1; r < REG_NUM; r++) begin
        cnt_q[r] <= '0;
      end
    end else begin
      for (int r = 1; r < REG_NUM; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
    end
  end

endmodule

`default_nettype wire
